// File: rtl/core_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// and the width of the data-streak counter.
package core_pkg;

  // Wide enough for the largest legal MAX_DATA_STREAK (15).
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and an LSU port onto one memory port with a single
// outstanding transaction; data has priority, bounded by a starvation guard.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned AWIDTH          = 32,
  parameter int unsigned DWIDTH          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                instr_req_i,
  input  logic [AWIDTH-1:0]   instr_addr_i,
  input  logic                instr_kill_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DWIDTH-1:0]   instr_rdata_o,

  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DWIDTH/8-1:0] data_be_i,
  input  logic [AWIDTH-1:0]   data_addr_i,
  input  logic [DWIDTH-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DWIDTH-1:0]   data_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i
);

  localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          r_state, w_state_next;
  arb_owner_t          r_owner, w_owner_next, w_owner;
  logic [STREAK_W-1:0] r_streak, w_streak_next;
  logic                r_kill_pend, w_kill_pend_next;
  logic                w_pick_instr, w_req, w_gnt;

  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;

  assign w_pick_instr = instr_req_i && (!data_req_i || (r_streak == MaxStreak));

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_owner          = r_owner;
    w_kill_pend_next = r_kill_pend;
    w_streak_next    = r_streak;
    w_req            = 1'b0;
    instr_rvalid_o   = 1'b0;
    data_rvalid_o    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (instr_req_i || data_req_i) begin
          w_req        = 1'b1;
          w_owner      = w_pick_instr ? OWNER_INSTR : OWNER_DATA;
          w_owner_next = w_owner;
          w_state_next = mem_gnt_i ? WAIT : REQ;
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (instr_kill_i && (r_owner == OWNER_INSTR)) w_kill_pend_next = 1'b1;
        if (mem_gnt_i) w_state_next = WAIT;
      end
      WAIT: begin
        if (instr_kill_i && (r_owner == OWNER_INSTR)) w_kill_pend_next = 1'b1;
        if (mem_rvalid_i) begin
          instr_rvalid_o   = (r_owner == OWNER_INSTR) && !r_kill_pend && !instr_kill_i;
          data_rvalid_o    = (r_owner == OWNER_DATA);
          w_kill_pend_next = 1'b0;
          w_state_next     = IDLE;
        end
      end
      default: begin
        w_state_next     = IDLE;
        w_kill_pend_next = 1'b0;
      end
    endcase

    // IDLE drives the request combinationally, so reset must mask it directly.
    w_req = w_req && rst_n_i;
    w_gnt = w_req && mem_gnt_i;

    if (w_gnt) begin
      if ((w_owner == OWNER_DATA) && instr_req_i) begin
        if (r_streak != MaxStreak) w_streak_next = r_streak + 1'b1;
      end else begin
        w_streak_next = '0;
      end
    end
  end

  always_comb begin
    mem_req_o   = w_req;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    instr_gnt_o = w_gnt && (w_owner == OWNER_INSTR);
    data_gnt_o  = w_gnt && (w_owner == OWNER_DATA);
    if (w_req) begin
      if (w_owner == OWNER_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_owner     <= OWNER_INSTR;
      r_streak    <= '0;
      r_kill_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_streak    <= w_streak_next;
      r_kill_pend <= w_kill_pend_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table, directed corner sequences,
// then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned MAX = 4;

  localparam logic [31:0] IADDR = 32'h0000_0080;
  localparam logic [31:0] DADDR = 32'h0000_1000;
  localparam logic [3:0]  DBE   = 4'hA;
  localparam logic [31:0] WD    = 32'h1234_5678;
  localparam logic [31:0] RD    = 32'hDEAD_BEEF;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          instr_req_i, instr_kill_i, instr_gnt_o, instr_rvalid_o;
  logic [AW-1:0] instr_addr_i;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [3:0]    data_be_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i, data_rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .AWIDTH          (AW),
    .DWIDTH          (DW),
    .MAX_DATA_STREAK (MAX)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_kill_i   (instr_kill_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  typedef struct packed {
    logic [5:0] in;   // ir, dr, we, kill, gnt, rv
    logic [1:0] sel;  // expected memory-side owner: 0 none, 1 fetch, 2 data
    logic [4:0] ex;   // mem_we, instr_gnt, data_gnt, instr_rvalid, data_rvalid
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [5:0] in, input logic [1:0] sel,
                              input logic [4:0] ex);
    vec_t v;
    v.in  = in;
    v.sel = sel;
    v.ex  = ex;
    return v;
  endfunction

  function automatic logic [159:0] pack(input logic req, input logic we, input logic [3:0] be,
                                        input logic [31:0] addr, input logic [31:0] wd,
                                        input logic ig, input logic dg, input logic irv,
                                        input logic drv, input logic [31:0] ird,
                                        input logic [31:0] drd);
    return {22'd0, req, we, be, addr, wd, ig, dg, irv, drv, ird, drd};
  endfunction

  function automatic logic [159:0] dut_vec();
    return pack(mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, instr_gnt_o,
                data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o);
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ir, input logic dr, input logic we, input logic kill,
                        input logic gnt, input logic rv);
    @(negedge clk_i);
    instr_req_i  = ir;
    data_req_i   = dr;
    data_we_i    = we;
    instr_kill_i = kill;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    #2;
  endtask

  task automatic fixed_fields();
    instr_addr_i = IADDR;
    data_addr_i  = DADDR;
    data_be_i    = DBE;
    data_wdata_i = WD;
    mem_rdata_i  = RD;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
    instr_kill_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    fixed_fields();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Random-phase reference model: one transaction record plus the data streak.
  bit m_busy, m_granted, m_own_i, m_killed;
  int m_streak;

  initial begin
    logic [159:0] exp;
    logic [31:0]  addr, wd;
    logic [3:0]   be;

    vecs[0]  = mk(6'b110010, 2'd2, 5'b00100);  // both request, data wins
    vecs[1]  = mk(6'b100000, 2'd0, 5'b00000);
    vecs[2]  = mk(6'b100001, 2'd0, 5'b00001);
    vecs[3]  = mk(6'b100000, 2'd1, 5'b00000);  // fetch served next, stalled
    vecs[4]  = mk(6'b100000, 2'd1, 5'b00000);
    vecs[5]  = mk(6'b110010, 2'd1, 5'b01000);  // owner frozen despite data
    vecs[6]  = mk(6'b010001, 2'd0, 5'b00010);
    vecs[7]  = mk(6'b011010, 2'd2, 5'b10100);  // write
    vecs[8]  = mk(6'b000010, 2'd0, 5'b00000);  // stray gnt in WAIT
    vecs[9]  = mk(6'b000101, 2'd0, 5'b00001);  // kill ignored for data owner
    vecs[10] = mk(6'b000001, 2'd0, 5'b00000);  // stray rvalid in IDLE
    vecs[11] = mk(6'b100010, 2'd1, 5'b01000);
    vecs[12] = mk(6'b000101, 2'd0, 5'b00000);  // kill with rvalid: suppressed
    vecs[13] = mk(6'b100010, 2'd1, 5'b01000);
    vecs[14] = mk(6'b000001, 2'd0, 5'b00010);  // next fetch delivered

    // Reset state with every request input active.
    rst_n_i = 1'b0;
    fixed_fields();
    instr_req_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b1;
    instr_kill_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #12;
    check("reset outputs",
          {mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o},
          '0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].in[5], vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1],
             vecs[i].in[0]);
      addr = '0; be = '0; wd = '0;
      if (vecs[i].sel == 2'd1) begin
        addr = IADDR; be = 4'hF;
      end else if (vecs[i].sel == 2'd2) begin
        addr = DADDR; be = DBE; wd = WD;
      end
      exp = pack(vecs[i].sel != 2'd0, vecs[i].ex[4], be, addr, wd, vecs[i].ex[3],
                 vecs[i].ex[2], vecs[i].ex[1], vecs[i].ex[0], RD, RD);
      check($sformatf("vector %0d", i), dut_vec(), exp);
    end

    // Starvation guard: D,D,D,D,I with both requests held.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("streak grant %0d", k), {instr_gnt_o, data_gnt_o},
            (k < 4) ? 2'b01 : 2'b10);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Grant stall: request and address hold for three cycles.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("stall cycle %0d", k), {mem_req_o, mem_addr_o, data_gnt_o},
            {1'b1, 32'h0000_1000, 1'b0});
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stall release gnt", {mem_req_o, data_gnt_o, instr_gnt_o}, 3'b110);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stall rvalid", {data_rvalid_o, instr_rvalid_o}, 2'b10);

    // Kill raised in WAIT, response arrives a cycle later.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("kill fetch gnt", {instr_gnt_o, mem_addr_o}, {1'b1, 32'h0000_0080});
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("killed response", {instr_rvalid_o, instr_rdata_o}, {1'b0, 32'hDEAD_BEEF});
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post-kill response", instr_rvalid_o, 1'b1);

    // Reset during WAIT, then a stray response.
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    #1 rst_n_i = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    check("async reset outputs",
          {mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o},
          '0);
    @(negedge clk_i);
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    rst_n_i = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stray rvalid after reset", {instr_rvalid_o, data_rvalid_o, mem_req_o}, 3'b000);

    // Randomized traffic against the model.
    do_reset();
    m_busy = 0; m_granted = 0; m_own_i = 0; m_killed = 0; m_streak = 0;
    for (int c = 0; c < 3000; c++) begin
      logic e_req, own_i, e_ig, e_dg, e_irv, e_drv;
      @(negedge clk_i);
      instr_req_i  = ($urandom_range(0, 99) < 55);
      data_req_i   = ($urandom_range(0, 99) < 60);
      data_we_i    = $urandom_range(0, 1) == 1;
      instr_kill_i = ($urandom_range(0, 99) < 10);
      mem_gnt_i    = ($urandom_range(0, 99) < 50);
      mem_rvalid_i = ($urandom_range(0, 99) < 40);
      instr_addr_i = $urandom;
      data_addr_i  = $urandom;
      data_be_i    = 4'($urandom);
      data_wdata_i = $urandom;
      mem_rdata_i  = $urandom;
      #2;
      e_req = 1'b0;
      own_i = m_own_i;
      if (!m_busy) begin
        if (instr_req_i || data_req_i) begin
          e_req = 1'b1;
          own_i = instr_req_i && (!data_req_i || (m_streak == MAX));
        end
      end else if (!m_granted) begin
        e_req = 1'b1;
      end
      e_ig  = e_req && own_i && mem_gnt_i;
      e_dg  = e_req && !own_i && mem_gnt_i;
      e_irv = m_busy && m_granted && mem_rvalid_i && own_i && !m_killed && !instr_kill_i;
      e_drv = m_busy && m_granted && mem_rvalid_i && !own_i;
      exp = pack(e_req, e_req && !own_i && data_we_i,
                 !e_req ? 4'h0 : (own_i ? 4'hF : data_be_i),
                 !e_req ? 32'h0 : (own_i ? instr_addr_i : data_addr_i),
                 (e_req && !own_i) ? data_wdata_i : 32'h0,
                 e_ig, e_dg, e_irv, e_drv, mem_rdata_i, mem_rdata_i);
      check($sformatf("random cycle %0d", c), dut_vec(), exp);

      if (e_ig || e_dg)
        m_streak = (e_dg && instr_req_i) ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
      if (!m_busy) begin
        if (e_req) begin
          m_busy = 1; m_own_i = own_i; m_granted = mem_gnt_i; m_killed = 0;
        end
      end else begin
        if (instr_kill_i && m_own_i) m_killed = 1;
        if (!m_granted) begin
          if (mem_gnt_i) m_granted = 1;
        end else if (mem_rvalid_i) begin
          m_busy = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk_i is the clock and rst_n_i is the reset.
REQ-002 Parameter AWIDTH, 32, address width.
REQ-003 Parameter DWIDTH, 32, data width; byte-enable width is DWIDTH/8.
REQ-004 Parameter MAX_DATA_STREAK, 4, maximum consecutive data grants while an instruction request waits; legal range 1..15.
REQ-005 Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  async active-low reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  AWIDTH  fetch address.
- instr_kill_i  in  1  discard the in-flight fetch response (pipeline flush).
- instr_gnt_o  out  1  fetch accepted by memory.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DWIDTH  fetch data.
- data_req_i  in  1  LSU request.
- data_we_i  in  1  LSU write.
- data_be_i  in  DWIDTH/8  byte enables.
- data_addr_i  in  AWIDTH  LSU address.
- data_wdata_i  in  DWIDTH  store data.
- data_gnt_o  out  1  LSU accepted.
- data_rvalid_o  out  1  LSU response valid.
- data_rdata_o  out  DWIDTH  load data.
- mem_req_o  out  1  memory request.
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/DWIDTH/8/AWIDTH/DWIDTH  muxed request fields.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response.
- mem_rdata_i  in  DWIDTH  response data.

Function
REQ-006 FSM states: IDLE, REQ, WAIT; exactly one transaction is outstanding at a time.
REQ-007 IDLE: if any request is pending, arbitrate combinationally, drive mem_req_o=1 with the winner's fields in the same cycle, and register the winner as owner. On mem_gnt_i go to WAIT; otherwise go to REQ.
REQ-008 Arbitration: data wins over instr, except when instr_req_i=1 and streak_cnt==MAX_DATA_STREAK; in that case instr wins.
REQ-009 streak_cnt is updated on every grant:
- +1 on a data grant while instr_req_i=1, saturating at MAX_DATA_STREAK.
- Cleared on an instr grant, or on a data grant while instr_req_i=0.
REQ-010 REQ: owner is frozen and mem_req_o=1 with the owner's fields. Requesters hold their request stable until gnt. On mem_gnt_i go to WAIT.
REQ-011 mem_gnt_i SHALL be routed only to the owner's gnt output, in the same cycle; the other gnt output stays 0.
REQ-012 WAIT: mem_req_o=0. On mem_rvalid_i, pulse the owner's rvalid output in the same cycle, then return to IDLE. This gives a one-cycle bubble between transactions.
REQ-013 instr_rdata_o and data_rdata_o SHALL both equal mem_rdata_i combinationally.
REQ-014 Kill: instr_kill_i=1 while owner=instr in REQ or WAIT sets kill_pend. The transaction still completes, but instr_rvalid_o is suppressed.
REQ-015 If instr_kill_i=1 in the same cycle as the instr mem_rvalid_i, that response SHALL be suppressed.
REQ-016 kill_pend clears on return to IDLE; instr_kill_i in IDLE, or while owner=data, has no effect.
REQ-017 When mem_req_o=0, mem_we_o and mem_be_o SHALL be 0.
REQ-018 mem_rvalid_i outside WAIT SHALL be ignored and SHALL produce no rvalid output.

Reset
REQ-019 On rst_n_i=0, regardless of state:
- State becomes IDLE; streak_cnt, owner and kill_pend are cleared.
- All gnt, rvalid, mem_req_o, mem_we_o and mem_be_o outputs read 0.
- A reset applied mid-transaction abandons that transaction without any response.

Structure
REQ-020 arb_state_t (IDLE/REQ/WAIT) and arb_owner_t (OWNER_INSTR/OWNER_DATA) SHALL be declared in core_pkg.
REQ-021 The block SHALL be a single module with no sub-module.

Verification
REQ-022 Directed scenario 1 (simultaneous requests): instr_req and data_req both 1, mem_gnt_i=1 in IDLE, rvalid 2 cycles later -> data_gnt_o=1 that cycle, instr_gnt_o=0, data_rvalid_o pulses once, instr is served next.
REQ-023 Directed scenario 2 (starvation guard): data_req held 1 for 5 transactions with instr_req held 1 -> grants are D,D,D,D,I (MAX_DATA_STREAK=4).
REQ-024 Directed scenario 3 (gnt stall): mem_gnt_i held 0 for 3 cycles -> mem_req_o=1 with addr 0x0000_1000 stable for all 3 cycles; gnt passes on the 4th cycle.
REQ-025 Directed scenario 4 (kill): fetch at 0x80 granted, instr_kill_i=1 in WAIT, mem_rvalid_i with rdata 0xDEADBEEF -> instr_rvalid_o stays 0; the next fetch response is delivered normally.
REQ-026 Directed scenario 5 (reset mid-transaction): rst_n_i low during WAIT -> all outputs 0 asynchronously; a stray mem_rvalid_i after release produces no rvalid.
